// File: rtl/seven_segment_mux.sv
// rtl/seven_segment_mux.sv - two-digit time-multiplexed 7-segment driver with frame-aligned updates
//
// Purpose:
//   Captures the BCD digit pair presented with a one-cycle load strobe and shows
//   it on a two-digit common-cathode display over one shared segment bus. A new
//   value is copied to the display only at a frame start, so a frame never mixes
//   old and new digits. Segments stay dark after every digit switch to avoid ghosting.
//
// Parameters:
//   REFRESH_DIV   clocks each digit stays selected (>= 2)
//   BLANK_CYCLES  dark clocks after each digit switch (0 <= BLANK_CYCLES < REFRESH_DIV)
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   load         in   one-cycle strobe qualifying ten_count/unit_count
//   ten_count    in   [3:0] tens digit, BCD
//   unit_count   in   [3:0] units digit, BCD
//   segments     out  [6:0] {g,f,e,d,c,b,a}, active-high, registered
//   digit        out  1 = tens digit selected, 0 = units digit selected, registered
//   dbg_pending  out  a captured value is waiting for the next frame start
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a zero tens digit is shown dark

module seven_segment_mux #(
   parameter int REFRESH_DIV  = 256,
   parameter int BLANK_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] ten_count,
   input  logic [3:0] unit_count,
   output logic [6:0] segments,
   output logic       digit,
   output logic       dbg_pending
);

   localparam int            CW         = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] LAST_CNT   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_INIT = CW'(BLANK_CYCLES);
   localparam logic [CW-1:0] ONE        = CW'(1);

   typedef enum logic {ST_SHOW, ST_BLANK} state_t;

   state_t        r_state,        w_state;
   logic [CW-1:0] r_refresh_cnt,  w_refresh_cnt;
   logic [CW-1:0] r_blank_cnt,    w_blank_cnt;
   logic          r_digit,        w_digit;
   logic [6:0]    r_segments,     w_segments;
   logic          r_pending,      w_pending;
   logic [3:0]    r_shadow_tens,  w_shadow_tens;
   logic [3:0]    r_shadow_units, w_shadow_units;
   logic [3:0]    r_disp_tens,    w_disp_tens;
   logic [3:0]    r_disp_units,   w_disp_units;

   logic          w_wrap;
   logic [3:0]    w_show_val;
   logic [6:0]    w_decoded;

   function automatic logic [6:0] f_decode(input logic [3:0] i_val);
      case (i_val)
         4'd0:    f_decode = 7'h3F;
         4'd1:    f_decode = 7'h06;
         4'd2:    f_decode = 7'h5B;
         4'd3:    f_decode = 7'h4F;
         4'd4:    f_decode = 7'h66;
         4'd5:    f_decode = 7'h6D;
         4'd6:    f_decode = 7'h7D;
         4'd7:    f_decode = 7'h07;
         4'd8:    f_decode = 7'h7F;
         4'd9:    f_decode = 7'h6F;
         default: f_decode = 7'h79;   // non-BCD shows 'E'
      endcase
   endfunction

   always_comb begin
      w_show_val = r_digit ? r_disp_tens : r_disp_units;
      w_decoded  = f_decode(w_show_val);
`ifdef LEADING_ZERO_BLANK_EN
      if (r_digit && (r_disp_tens == 4'd0)) begin
         w_decoded = 7'b0;
      end
`endif
   end

   always_comb begin
      w_state        = r_state;
      w_blank_cnt    = r_blank_cnt;
      w_digit        = r_digit;
      w_segments     = r_segments;
      w_pending      = r_pending;
      w_shadow_tens  = r_shadow_tens;
      w_shadow_units = r_shadow_units;
      w_disp_tens    = r_disp_tens;
      w_disp_units   = r_disp_units;

      w_wrap        = (r_refresh_cnt == LAST_CNT);
      w_refresh_cnt = w_wrap ? '0 : r_refresh_cnt + ONE;

      if (w_wrap) begin
         // The segment register lags digit by a clock, so the first output after a
         // switch is always dark; that clock counts toward the blanking gap.
         w_digit    = ~r_digit;
         w_segments = 7'b0;
         if (BLANK_CYCLES > 0) begin
            w_state     = ST_BLANK;
            w_blank_cnt = BLANK_INIT;
         end else begin
            w_state = ST_SHOW;
         end
         // Frame start: tens half ending, units half about to begin.
         if (r_digit && r_pending) begin
            w_disp_tens  = r_shadow_tens;
            w_disp_units = r_shadow_units;
            w_pending    = 1'b0;
         end
      end else begin
         case (r_state)
            ST_BLANK: begin
               w_blank_cnt = r_blank_cnt - ONE;
               if (r_blank_cnt == ONE) begin
                  // Leaving BLANK: register the new digit now so the dark gap is
                  // exactly BLANK_CYCLES clocks including the forced one at the switch.
                  w_state    = ST_SHOW;
                  w_segments = w_decoded;
               end else begin
                  w_segments = 7'b0;
               end
            end
            default: begin
               w_segments = w_decoded;
            end
         endcase
      end

      // Capture after the frame-start transfer so a coincident load stays pending.
      if (load) begin
         w_shadow_tens  = ten_count;
         w_shadow_units = unit_count;
         w_pending      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_SHOW;
         r_refresh_cnt  <= '0;
         r_blank_cnt    <= '0;
         r_digit        <= 1'b0;
         r_segments     <= 7'b0;
         r_pending      <= 1'b0;
         r_shadow_tens  <= 4'd0;
         r_shadow_units <= 4'd0;
         r_disp_tens    <= 4'd0;
         r_disp_units   <= 4'd0;
      end else begin
         r_state        <= w_state;
         r_refresh_cnt  <= w_refresh_cnt;
         r_blank_cnt    <= w_blank_cnt;
         r_digit        <= w_digit;
         r_segments     <= w_segments;
         r_pending      <= w_pending;
         r_shadow_tens  <= w_shadow_tens;
         r_shadow_units <= w_shadow_units;
         r_disp_tens    <= w_disp_tens;
         r_disp_units   <= w_disp_units;
      end
   end

   assign segments    = r_segments;
   assign digit       = r_digit;
   assign dbg_pending = r_pending;

endmodule

// File: tb/tb_seven_segment_mux.sv
// tb/tb_seven_segment_mux.sv - scoreboard bench for seven_segment_mux

module tb_seven_segment_mux;

   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = 2 * DIV;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b1;
   logic       load       = 1'b0;
   logic [3:0] ten_count  = 4'd0;
   logic [3:0] unit_count = 4'd0;
   logic [6:0] segments;
   logic       digit;
   logic       dbg_pending;

   seven_segment_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (load),
      .ten_count   (ten_count),
      .unit_count  (unit_count),
      .segments    (segments),
      .digit       (digit),
      .dbg_pending (dbg_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c;
      int tens;
      int units;
   } load_t;

   typedef struct {
      int         t;
      logic [6:0] seg;
      logic       dig;
      logic       pend;
   } exp_t;

   load_t loads[$];
   exp_t  exp_q[$];
   exp_t  mon_e;
   int    cyc      = 0;
   bit    model_on = 1'b0;
   int    tests    = 0;
   int    fails    = 0;
   int    seg_tbl[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   // Cycle t counts clock edges since reset release. Frame j spans cycles
   // [16j, 16j+16): units digit first half, tens digit second half.
   function automatic exp_t calc(input int t);
      exp_t e;
      int   j, best, tens, units, shown;
      j     = t / FRAME;
      best  = -1;
      tens  = 0;
      units = 0;
      e.pend = 1'b0;
      foreach (loads[i]) begin
         // A load in cycle c reaches the display at the first frame start after c+1.
         if (loads[i].c <= FRAME * j - 2 && loads[i].c > best) begin
            best  = loads[i].c;
            tens  = loads[i].tens;
            units = loads[i].units;
         end
         if (loads[i].c >= FRAME * j - 1 && loads[i].c < t) e.pend = 1'b1;
      end
      e.t   = t;
      e.dig = ((t / DIV) % 2) == 1;
      shown = e.dig ? tens : units;
      if (t == 0 || (t >= DIV && (t % DIV) < BLK)) e.seg = 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
      else if (e.dig && tens == 0) e.seg = 7'h00;
`endif
      else if (shown > 9) e.seg = 7'h79;
      else e.seg = 7'(seg_tbl[shown]);
      return e;
   endfunction

   always @(posedge clk) begin
      if (model_on) begin
         cyc = cyc + 1;
         exp_q.push_back(calc(cyc));
      end
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         tests = tests + 1;
         if (segments !== mon_e.seg || digit !== mon_e.dig || dbg_pending !== mon_e.pend) begin
            fails = fails + 1;
            $display("FAIL cycle %0d: seg=%h digit=%b pending=%b, expected seg=%h digit=%b pending=%b",
                     mon_e.t, segments, digit, dbg_pending, mon_e.seg, mon_e.dig, mon_e.pend);
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      tests = tests + 1;
      if (act != req) begin
         fails = fails + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      model_on = 1'b0;
      exp_q.delete();
      reset_n    = 1'b0;
      load       = 1'b1;
      ten_count  = 4'd4;
      unit_count = 4'd5;
      #1;
      chk("reset_segments", int'(segments), 0);
      chk("reset_digit", int'(digit), 0);
      chk("reset_pending", int'(dbg_pending), 0);
      repeat (2) @(posedge clk);
      #2 load = 1'b0;
      @(posedge clk);
      #2;
      loads.delete();
      cyc     = 0;
      reset_n = 1'b1;
      exp_q.push_back(calc(0));
      model_on = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int t, input int u);
      load       = 1'b1;
      ten_count  = 4'(t);
      unit_count = 4'(u);
      loads.push_back('{cyc, t, u});
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_phase(input int p);
      int guard;
      guard = 0;
      while ((cyc % FRAME) != p && guard < 2 * FRAME) begin
         @(negedge clk);
         guard = guard + 1;
      end
      chk("wait_phase", cyc % FRAME, p);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      idle(32);

      wait_phase(3);  pulse(4, 2);  idle(40);

      wait_phase(5);  pulse(4, 2);
      wait_phase(15); pulse(1, 7);  idle(40);

      wait_phase(2);  pulse(9, 9);  pulse(1, 1);  idle(40);

      wait_phase(4);  pulse(12, 15); idle(36);

      wait_phase(4);  pulse(0, 8);  idle(36);

      wait_phase(5);
      do_reset();
      @(negedge clk);
      idle(24);

      repeat (30) begin
         idle(int'($urandom_range(0, 20)));
         pulse(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      idle(40);

      model_on = 1'b0;
      idle(4);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
